// File: rtl/mm_spart_pkg.sv
// mm_spart_pkg: shared definitions for the memory-mapped serial port.
//   - register offsets within the four-word window
//   - STATUS register bit positions
//   - state encoding shared by the TX and RX bit engines
//   - smallest usable baud divisor
package mm_spart_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  localparam int ST_FRAME_ERR    = 9;
  localparam int ST_RX_OVERRUN   = 8;
  localparam int ST_TX_FREE_LSB  = 4;
  localparam int ST_RX_COUNT_LSB = 0;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} spart_state_e;

endpackage

// File: rtl/mm_spart_fifo.sv
// spart_fifo: small synchronous FIFO with show-ahead read data.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers/count only)
//   push, wdata   write request and data; accepted when not full or popping
//   pop           read request; ignored when empty
//   rdata         head entry (valid when !empty)
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap on their own.
module spart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mm_spart.sv
// mm_spart: memory-mapped 8N1 serial port on the CPU data bus.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   addr       bus word address; the block answers BASE_ADDR..BASE_ADDR+3
//   re, we     read / write strobes (write wins when both are set)
//   wdata      write data
//   rdata      combinational read data, 16'hDEAD when not addressed
//   rxd        asynchronous serial input
//   txd        registered serial output, idles high
// Registers: +0 DATA (TX push / RX pop), +1 STATUS, +2 DIV, +3 reserved.
module mm_spart
  import mm_spart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hC004,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        rxd,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [15:0] sat_div(input logic [15:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  logic           hit, wr_acc, rd_acc;
  logic [1:0]     off;
  logic [15:0]    div_q, status_w;
  logic           frame_err, rx_overrun, stat_clr, ovr_set;
  logic [3:0]     tx_free;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_head;
  logic [CW-1:0]  tx_count;
  logic           rx_pop, rx_full, rx_empty, rx_push_req, rx_frame_set;
  logic [7:0]     rx_head;
  logic [CW-1:0]  rx_count;

  assign hit      = (addr[15:2] == BASE_ADDR[15:2]);
  assign off      = addr[1:0];
  assign wr_acc   = hit & we;
  assign rd_acc   = hit & re & ~we;
  assign tx_push  = wr_acc & (off == OFF_DATA) & (~tx_full | tx_pop);
  assign rx_pop   = rd_acc & (off == OFF_DATA) & ~rx_empty;
  assign stat_clr = rd_acc & (off == OFF_STATUS);
  assign ovr_set  = rx_push_req & rx_full & ~rx_pop;
  assign tx_free  = 4'(FIFO_DEPTH) - 4'(tx_count);

  spart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(wdata[7:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  logic [7:0] rx_sh;

  spart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_req), .pop(rx_pop), .wdata(rx_sh),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    status_w = '0;
    status_w[ST_FRAME_ERR]             = frame_err;
    status_w[ST_RX_OVERRUN]            = rx_overrun;
    status_w[ST_TX_FREE_LSB +: 4]      = tx_free;
    status_w[ST_RX_COUNT_LSB +: 4]     = 4'(rx_count);
  end

  always_comb begin
    rdata = 16'hDEAD;
    if (hit) begin
      case (off)
        OFF_DATA:   rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
        OFF_STATUS: rdata = status_w;
        OFF_DIV:    rdata = div_q;
        default:    rdata = 16'h0000;
      endcase
    end
  end

  // A status read clears the sticky errors, but an error raised on that edge survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= DEFAULT_DIV;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr_acc && off == OFF_DIV) div_q <= sat_div(wdata);
      frame_err  <= rx_frame_set | (frame_err & ~stat_clr);
      rx_overrun <= ovr_set | (rx_overrun & ~stat_clr);
    end
  end

  // ---------------- TX bit engine ----------------
  spart_state_e tx_state, tx_state_d;
  logic [15:0]  tx_cnt, tx_div;
  logic [2:0]   tx_bit;
  logic [7:0]   tx_sh;
  logic         tx_bit_end, tx_bit_start, txd_q;

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  assign txd        = txd_q;

  always_comb begin
    tx_state_d   = tx_state;
    tx_pop       = 1'b0;
    tx_bit_start = 1'b0;
    case (tx_state)
      IDLE:  if (!tx_empty) begin tx_state_d = START; tx_pop = 1'b1; tx_bit_start = 1'b1; end
      START: if (tx_bit_end) begin tx_state_d = DATA; tx_bit_start = 1'b1; end
      DATA:  if (tx_bit_end) begin
               tx_bit_start = 1'b1;
               if (tx_bit == 3'd7) tx_state_d = STOP;
             end
      STOP:  if (tx_bit_end) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  // txd is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_div   <= DEFAULT_DIV;
      tx_bit   <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      if (tx_bit_start) begin
        tx_cnt <= '0;
        tx_div <= div_q;
      end else if (tx_state_d == IDLE) begin
        tx_cnt <= '0;
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
      if (tx_state == DATA && tx_bit_end) tx_bit <= tx_bit + 3'd1;
      txd_q <= (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_sh[0] : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) tx_sh <= tx_head;
    else if (tx_state == DATA && tx_bit_end) tx_sh <= {1'b0, tx_sh[7:1]};
  end

  // ---------------- RX synchronizer: rxd -> _p0 -> _p1 ----------------
  logic rxd_p0, rxd_p1, rxd_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0   <= 1'b1;
      rxd_p1   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_p0   <= rxd;
      rxd_p1   <= rxd_p0;
      rxd_prev <= rxd_p1;
    end
  end

  // ---------------- RX bit engine ----------------
  spart_state_e rx_state, rx_state_d;
  logic [15:0]  rx_cnt, rx_div, rx_half;
  logic [2:0]   rx_bit;
  logic         rx_mid, rx_bit_end, rx_bit_start, rx_sample;

  assign rx_half    = {1'b0, rx_div[15:1]};
  assign rx_mid     = (rx_cnt == rx_half - 16'd1);
  assign rx_bit_end = (rx_cnt == rx_div - 16'd1);

  always_comb begin
    rx_state_d   = rx_state;
    rx_bit_start = 1'b0;
    rx_sample    = 1'b0;
    rx_push_req  = 1'b0;
    rx_frame_set = 1'b0;
    case (rx_state)
      IDLE:  if (rxd_prev && !rxd_p1) begin rx_state_d = START; rx_bit_start = 1'b1; end
      // Mid-start re-check: a line already back high was only a glitch.
      START: if (rx_mid) begin
               if (rxd_p1) rx_state_d = IDLE;
               else begin rx_state_d = DATA; rx_bit_start = 1'b1; end
             end
      DATA:  if (rx_bit_end) begin
               rx_sample    = 1'b1;
               rx_bit_start = 1'b1;
               if (rx_bit == 3'd7) rx_state_d = STOP;
             end
      STOP:  if (rx_bit_end) begin
               rx_state_d   = IDLE;
               rx_push_req  = rxd_p1;
               rx_frame_set = ~rxd_p1;
             end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_div   <= DEFAULT_DIV;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_d;
      if (rx_bit_start) begin
        rx_cnt <= '0;
        rx_div <= div_q;
      end else if (rx_state_d == IDLE) begin
        rx_cnt <= '0;
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
      if (rx_sample) rx_bit <= rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_sample) rx_sh <= {rxd_p1, rx_sh[7:1]};
  end

endmodule
